regfile_arb: RTL and testbench

REGFILE_ARB -- requirements
Module: regfile_arb

---
 rtl/regfile_arb_pkg.sv | 20 ++
 rtl/regfile_arb_rr_starve_arb.sv | 84 ++++++++
 rtl/regfile_arb.sv | 142 ++++++++++++++
 tb/tb_regfile_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared processor definitions: register file geometry, arbiter FSM states
// and the grant selection encoding.
package regfile_arb_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_RD0  = 2'd2,
    GNT_RD1  = 2'd3
  } gnt_sel_t;

endpackage

// File: rtl/regfile_arb_rr_starve_arb.sv
// Two-reader round-robin picker with per-reader starve counters. A starved
// reader outranks the writeback port, which in turn outranks normal reads.
module rr_starve_arb
  import regfile_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic wb_req,
  input  logic rd0_req,
  input  logic rd1_req,
  output logic wb_gnt,
  output logic rd0_gnt,
  output logic rd1_gnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve0;
  logic [CNT_W-1:0] starve1;
  logic             ptr;
  logic             hot0;
  logic             hot1;
  gnt_sel_t         pick;

  // Priority pick; ptr names the reader that wins the next tie.
  always_comb begin
    hot0 = rd0_req && (starve0 == LIMIT);
    hot1 = rd1_req && (starve1 == LIMIT);
    pick = GNT_NONE;
    if (!en) begin
      pick = GNT_NONE;
    end else if (hot0 && hot1) begin
      pick = ptr ? GNT_RD1 : GNT_RD0;
    end else if (hot0) begin
      pick = GNT_RD0;
    end else if (hot1) begin
      pick = GNT_RD1;
    end else if (wb_req) begin
      pick = GNT_WB;
    end else if (rd0_req && rd1_req) begin
      pick = ptr ? GNT_RD1 : GNT_RD0;
    end else if (rd0_req) begin
      pick = GNT_RD0;
    end else if (rd1_req) begin
      pick = GNT_RD1;
    end else begin
      pick = GNT_NONE;
    end
  end

  assign wb_gnt  = (pick == GNT_WB);
  assign rd0_gnt = (pick == GNT_RD0);
  assign rd1_gnt = (pick == GNT_RD1);

  // Starve counters saturate at the limit; pointer flips away from the last reader served.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve0 <= {CNT_W{1'b0}};
      starve1 <= {CNT_W{1'b0}};
      ptr     <= 1'b0;
    end else begin
      if (!rd0_req || rd0_gnt) begin
        starve0 <= {CNT_W{1'b0}};
      end else if (starve0 != LIMIT) begin
        starve0 <= starve0 + CNT_W'(1);
      end
      if (!rd1_req || rd1_gnt) begin
        starve1 <= {CNT_W{1'b0}};
      end else if (starve1 != LIMIT) begin
        starve1 <= starve1 + CNT_W'(1);
      end
      if (rd0_gnt) begin
        ptr <= 1'b1;
      end else if (rd1_gnt) begin
        ptr <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_arb.sv
// Single-port register file arbiter: one writeback writer, two readers, and a
// post-reset sweep that zeroes every register before normal traffic runs.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_gnt,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic [ADDR_W-1:0] rf_sel,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              clr_busy
);

  rf_state_t         state;
  rf_state_t         state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] sel_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic              rd0_pend;
  logic              rd1_pend;
  logic              run;

  // rst is also applied combinationally so it beats any same-cycle grant.
  assign run = (state == ST_RUN) && !rst;

  rr_starve_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .wb_req (wb_req),
    .rd0_req(rd0_req),
    .rd1_req(rd1_req),
    .wb_gnt (wb_gnt),
    .rd0_gnt(rd0_gnt),
    .rd1_gnt(rd1_gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave CLEAR once the last index has been written.
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == {ADDR_W{1'b1}}) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_CLEAR;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_CLEAR;
    endcase
  end

  // Clear sweep index.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= {ADDR_W{1'b0}};
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // Register file port drive; idle cycles replay the held index and data.
  always_comb begin
    rf_wr    = 1'b0;
    rf_rd    = 1'b0;
    rf_sel   = sel_hold;
    rf_wdata = wdata_hold;
    if (rst) begin
      rf_wr = 1'b0;
    end else if (state == ST_CLEAR) begin
      rf_wr    = 1'b1;
      rf_sel   = clr_cnt;
      rf_wdata = {DATA_W{1'b0}};
    end else if (wb_gnt) begin
      rf_wr    = 1'b1;
      rf_sel   = wb_addr;
      rf_wdata = wb_data;
    end else if (rd0_gnt) begin
      rf_rd  = 1'b1;
      rf_sel = rd0_addr;
    end else if (rd1_gnt) begin
      rf_rd  = 1'b1;
      rf_sel = rd1_addr;
    end else begin
      rf_rd = 1'b0;
    end
  end

  // Hold registers and the one-deep read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_hold   <= {ADDR_W{1'b0}};
      wdata_hold <= {DATA_W{1'b0}};
      rd0_pend   <= 1'b0;
      rd1_pend   <= 1'b0;
    end else begin
      sel_hold   <= rf_sel;
      wdata_hold <= rf_wdata;
      rd0_pend   <= rd0_gnt;
      rd1_pend   <= rd1_gnt;
    end
  end

  assign rd0_valid = rd0_pend && !rst;
  assign rd1_valid = rd1_pend && !rst;
  assign rd0_data  = rd0_valid ? rf_rdata : {DATA_W{1'b0}};
  assign rd1_data  = rd1_valid ? rf_rdata : {DATA_W{1'b0}};
  assign clr_busy  = rst || (state == ST_CLEAR);

endmodule

// File: tb/tb_regfile_arb.sv
// Directed bench for regfile_arb with a behavioural registered register file.
module tb_regfile_arb;

  logic        clk;
  logic        rst;
  logic        wb_req;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_gnt;
  logic        rd0_req;
  logic [3:0]  rd0_addr;
  logic        rd0_gnt;
  logic        rd0_valid;
  logic [15:0] rd0_data;
  logic        rd1_req;
  logic [3:0]  rd1_addr;
  logic        rd1_gnt;
  logic        rd1_valid;
  logic [15:0] rd1_data;
  logic [3:0]  rf_sel;
  logic        rf_wr;
  logic        rf_rd;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata;
  logic        clr_busy;

  logic [15:0] mem [16];
  int          n_cmp;
  int          n_err;

  regfile_arb dut (
    .clk      (clk),
    .rst      (rst),
    .wb_req   (wb_req),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_gnt   (wb_gnt),
    .rd0_req  (rd0_req),
    .rd0_addr (rd0_addr),
    .rd0_gnt  (rd0_gnt),
    .rd0_valid(rd0_valid),
    .rd0_data (rd0_data),
    .rd1_req  (rd1_req),
    .rd1_addr (rd1_addr),
    .rd1_gnt  (rd1_gnt),
    .rd1_valid(rd1_valid),
    .rd1_data (rd1_data),
    .rf_sel   (rf_sel),
    .rf_wr    (rf_wr),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .clr_busy (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: garbage-filled on rst so the clear sweep is observable.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hDEAD;
      rf_rdata <= 16'h0000;
    end else begin
      if (rf_wr) mem[rf_sel] <= rf_wdata;
      if (rf_rd) rf_rdata <= mem[rf_sel];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    wb_req = 1'b1; wb_addr = a; wb_data = d;
    #1;
    chk("wr_gnt", wb_gnt, 1);
    chk("wr_strobe", rf_wr, 1);
    chk("wr_sel", rf_sel, a);
    chk("wr_data", rf_wdata, d);
    step();
    wb_req = 1'b0;
  endtask

  task automatic do_read(input logic which, input logic [3:0] a, input logic [15:0] expd);
    if (which) begin rd1_req = 1'b1; rd1_addr = a; end
    else begin rd0_req = 1'b1; rd0_addr = a; end
    #1;
    chk("rd_gnt", which ? rd1_gnt : rd0_gnt, 1);
    chk("rd_strobe", rf_rd, 1);
    chk("rd_no_wr", rf_wr, 0);
    chk("rd_sel", rf_sel, a);
    step();
    rd0_req = 1'b0; rd1_req = 1'b0;
    #1;
    chk("rd_valid", which ? rd1_valid : rd0_valid, 1);
    chk("rd_data", which ? rd1_data : rd0_data, expd);
    step();
    chk("rd_valid_once", which ? rd1_valid : rd0_valid, 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    wb_req = 1'b0; wb_addr = 4'h0; wb_data = 16'h0000;
    rd0_req = 1'b0; rd0_addr = 4'h0; rd1_req = 1'b0; rd1_addr = 4'h0;
    step();
    rst = 1'b0;
    chk("rst_busy", clr_busy, 1);
    chk("rst_v0", rd0_valid, 0);
    chk("rst_v1", rd1_valid, 0);
    chk("rst_d0", rd0_data, 0);
    chk("rst_d1", rd1_data, 0);

    // Clear sweep with a write pending: it must wait until RUN.
    wb_req = 1'b1; wb_addr = 4'h5; wb_data = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("clr_wr", rf_wr, 1);
      chk("clr_sel", rf_sel, i);
      chk("clr_wdata", rf_wdata, 0);
      chk("clr_busy", clr_busy, 1);
      chk("clr_no_gnt", wb_gnt, 0);
      step();
    end
    #1;
    chk("run_busy", clr_busy, 0);
    chk("first_wgnt", wb_gnt, 1);
    chk("first_wsel", rf_sel, 5);
    chk("first_wdata", rf_wdata, 16'h1234);
    step();
    wb_req = 1'b0;
    #1;
    chk("idle_wr", rf_wr, 0);
    chk("idle_rd", rf_rd, 0);
    chk("idle_sel_hold", rf_sel, 5);
    chk("idle_wdata_hold", rf_wdata, 16'h1234);
    step();

    // Write then read of the same index on the next cycle.
    do_write(4'h3, 16'hBEEF);
    do_read(1'b0, 4'h3, 16'hBEEF);
    do_read(1'b1, 4'h5, 16'h1234);
    do_read(1'b1, 4'h9, 16'h0000);

    // Both readers held: strict alternation starting with reader 0.
    rd0_req = 1'b1; rd0_addr = 4'h3; rd1_req = 1'b1; rd1_addr = 4'h5;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("alt_g0", rd0_gnt, (k % 2) == 0);
      chk("alt_g1", rd1_gnt, (k % 2) == 1);
      if (k > 0) begin
        chk("alt_v0", rd0_valid, (k % 2) == 1);
        chk("alt_v1", rd1_valid, (k % 2) == 0);
        chk("alt_d", (k % 2) == 1 ? rd0_data : rd1_data, (k % 2) == 1 ? 16'hBEEF : 16'h1234);
      end
      step();
    end
    rd0_req = 1'b0; rd1_req = 1'b0;
    #1;
    chk("alt_last_v1", rd1_valid, 1);
    chk("alt_last_d1", rd1_data, 16'h1234);
    step();

    // Writer hogging the port: reader 1 forced through every fifth cycle.
    wb_req = 1'b1; wb_addr = 4'h7; wb_data = 16'h00A5;
    rd1_req = 1'b1; rd1_addr = 4'h7;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("starve_wg", wb_gnt, (k % 5) != 4);
      chk("starve_rg", rd1_gnt, (k % 5) == 4);
      chk("starve_v1", rd1_valid, k == 5);
      if (k == 5) chk("starve_d1", rd1_data, 16'h00A5);
      step();
    end
    wb_req = 1'b0; rd1_req = 1'b0;
    #1;
    chk("starve_last_v1", rd1_valid, 1);
    chk("starve_last_d1", rd1_data, 16'h00A5);
    step();

    // Reset the cycle after a read grant squashes the returning data.
    rd0_req = 1'b1; rd0_addr = 4'h3;
    #1;
    chk("sq_gnt", rd0_gnt, 1);
    step();
    rd0_req = 1'b0; rst = 1'b1;
    #1;
    chk("sq_v0", rd0_valid, 0);
    chk("sq_d0", rd0_data, 0);
    chk("sq_busy", clr_busy, 1);
    chk("sq_no_wr", rf_wr, 0);
    step();
    rst = 1'b0;

    // Clear restarts at 0; reset again at index 7 restarts it once more.
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rc_sel", rf_sel, i);
      chk("rc_wr", rf_wr, 1);
      chk("rc_v0", rd0_valid, 0);
      if (i == 7) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("rc2_sel", rf_sel, i);
      chk("rc2_busy", clr_busy, 1);
      step();
    end
    #1;
    chk("rc2_done", clr_busy, 0);
    do_read(1'b0, 4'h5, 16'h0000);
    do_read(1'b1, 4'h3, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
